// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the four-stage nand_cpu: zero-cycle combinational hazard response from registered state.
// Backpressure: stalls hold F/D/A on d_cache wait, load-use or halt drain; saturating perf counters for debug.
module pipeline_controller #(
   parameter int REG_AW   = 4,
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              d_valid,
   input  logic              d_rs_valid,
   input  logic [REG_AW-1:0] d_rs,
   input  logic              d_is_halt,
   input  logic              a_valid,
   input  logic              a_is_load,
   input  logic              a_is_mem,
   input  logic              a_rd_valid,
   input  logic [REG_AW-1:0] a_rd,
   input  logic              a_mispredict,
   input  logic              dc_ready,
   output logic              stall_f,
   output logic              stall_d,
   output logic              stall_a,
   output logic              flush_d,
   output logic              bubble_a,
   output logic              bubble_w,
   output logic              redirect,
   output logic              halted,
   output logic              mem_fault,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      DRAIN    = 2'd2,
      HALTED   = 2'd3
   } state_t;

   localparam logic [7:0]       MAX_W8  = 8'(MAX_WAIT);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d;
   logic             drain_cnt_q, drain_cnt_d;
   logic             mem_fault_q, mem_fault_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic stall_f_c, stall_d_c, stall_a_c, flush_d_c;
   logic bubble_a_c, bubble_w_c, redirect_c, halted_c;
   logic front_eval;

   logic mem_hz, mispredict_hz, load_use_hz, halt_hz;

   always_comb begin
      mem_hz        = a_valid & a_is_mem & ~dc_ready;
      mispredict_hz = a_valid & a_mispredict;
      load_use_hz   = a_valid & a_is_load & a_rd_valid & d_valid & d_rs_valid
                      & (d_rs == a_rd);
      halt_hz       = d_valid & d_is_halt;
   end

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      drain_cnt_d = drain_cnt_q;
      mem_fault_d = mem_fault_q;
      stall_f_c   = 1'b0;
      stall_d_c   = 1'b0;
      stall_a_c   = 1'b0;
      flush_d_c   = 1'b0;
      bubble_a_c  = 1'b0;
      bubble_w_c  = 1'b0;
      redirect_c  = 1'b0;
      halted_c    = 1'b0;
      front_eval  = 1'b0;

      case (state_q)
         RUN: begin
            if (mem_hz) begin
               stall_f_c  = 1'b1;
               stall_d_c  = 1'b1;
               stall_a_c  = 1'b1;
               bubble_w_c = 1'b1;
               state_d    = MEM_WAIT;
               wait_cnt_d = 8'd1;
            end else begin
               front_eval = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (!dc_ready) begin
               stall_f_c  = 1'b1;
               stall_d_c  = 1'b1;
               stall_a_c  = 1'b1;
               bubble_w_c = 1'b1;
               if (wait_cnt_q >= MAX_W8) begin
                  mem_fault_d = 1'b1;
                  state_d     = HALTED;
               end else begin
                  wait_cnt_d = wait_cnt_q + 8'd1;
               end
            end else begin
               // access completes: release stalls and judge D/A in the same cycle
               state_d    = RUN;
               front_eval = 1'b1;
            end
         end
         DRAIN: begin
            stall_f_c = 1'b1;
            flush_d_c = 1'b1;
            if (drain_cnt_q) begin
               state_d = HALTED;
            end else begin
               drain_cnt_d = 1'b1;
            end
         end
         HALTED: begin
            stall_f_c  = 1'b1;
            stall_d_c  = 1'b1;
            stall_a_c  = 1'b1;
            flush_d_c  = 1'b1;
            bubble_a_c = 1'b1;
            bubble_w_c = 1'b1;
            halted_c   = 1'b1;
         end
         default: begin
            state_d = RUN;
         end
      endcase

      // mispredict wins: anything sitting in D is on the wrong path
      if (front_eval) begin
         if (mispredict_hz) begin
            redirect_c = 1'b1;
            flush_d_c  = 1'b1;
            bubble_a_c = 1'b1;
         end else if (load_use_hz) begin
            stall_f_c  = 1'b1;
            stall_d_c  = 1'b1;
            bubble_a_c = 1'b1;
         end else if (halt_hz) begin
            stall_f_c   = 1'b1;
            flush_d_c   = 1'b1;
            state_d     = DRAIN;
            drain_cnt_d = 1'b0;
         end
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_f_c && (state_q != HALTED) && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      if (redirect_c && !(&flush_cnt_q)) begin
         flush_cnt_d = flush_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= RUN;
         wait_cnt_q  <= 8'd0;
         drain_cnt_q <= 1'b0;
         mem_fault_q <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         mem_fault_q <= mem_fault_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // controls are forced low while reset is held, whatever the hazard inputs show
   assign stall_f   = n_rst & stall_f_c;
   assign stall_d   = n_rst & stall_d_c;
   assign stall_a   = n_rst & stall_a_c;
   assign flush_d   = n_rst & flush_d_c;
   assign bubble_a  = n_rst & bubble_a_c;
   assign bubble_w  = n_rst & bubble_w_c;
   assign redirect  = n_rst & redirect_c;
   assign halted    = n_rst & halted_c;
   assign mem_fault = mem_fault_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Bench for pipeline_controller: vector table, directed corner sequences, random run against a reference model.
module tb_pipeline_controller;

   localparam int AW   = 4;
   localparam int MAXW = 4;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          n_rst = 1'b0;
   logic          d_valid = 1'b0, d_rs_valid = 1'b0, d_is_halt = 1'b0;
   logic [AW-1:0] d_rs = '0, a_rd = '0;
   logic          a_valid = 1'b0, a_is_load = 1'b0, a_is_mem = 1'b0, a_rd_valid = 1'b0;
   logic          a_mispredict = 1'b0, dc_ready = 1'b1;
   logic          stall_f, stall_d, stall_a, flush_d, bubble_a, bubble_w;
   logic          redirect, halted, mem_fault;
   logic [CW-1:0] stall_cnt, flush_cnt;

   pipeline_controller #(.REG_AW(AW), .MAX_WAIT(MAXW), .CNT_W(CW)) dut (
      .clk(clk), .n_rst(n_rst),
      .d_valid(d_valid), .d_rs_valid(d_rs_valid), .d_rs(d_rs), .d_is_halt(d_is_halt),
      .a_valid(a_valid), .a_is_load(a_is_load), .a_is_mem(a_is_mem),
      .a_rd_valid(a_rd_valid), .a_rd(a_rd), .a_mispredict(a_mispredict),
      .dc_ready(dc_ready),
      .stall_f(stall_f), .stall_d(stall_d), .stall_a(stall_a), .flush_d(flush_d),
      .bubble_a(bubble_a), .bubble_w(bubble_w), .redirect(redirect),
      .halted(halted), .mem_fault(mem_fault),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model: plain flags and cycle counts
   bit m_halted, m_fault, m_wait;
   int m_drain_left, m_waits_seen, m_stall, m_flush;
   bit n_halted, n_fault, n_wait;
   int n_drain_left, n_waits_seen, n_stall, n_flush;

   // {stall_f,stall_d,stall_a,flush_d,bubble_a,bubble_w,redirect,halted,mem_fault}
   function automatic logic [8:0] outs();
      return {stall_f, stall_d, stall_a, flush_d, bubble_a, bubble_w, redirect, halted, mem_fault};
   endfunction

   task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", nm, got, want, $time);
      end
   endtask

   task automatic model_clear();
      m_halted = 0; m_fault = 0; m_wait = 0;
      m_drain_left = 0; m_waits_seen = 0; m_stall = 0; m_flush = 0;
   endtask

   task automatic set_in(input bit dv, input bit drv, input int drs, input bit dh,
                         input bit av, input bit al, input bit am, input bit ardv,
                         input int ard, input bit amp, input bit dcr);
      d_valid = dv; d_rs_valid = drv; d_rs = AW'(drs); d_is_halt = dh;
      a_valid = av; a_is_load = al; a_is_mem = am; a_rd_valid = ardv;
      a_rd = AW'(ard); a_mispredict = amp; dc_ready = dcr;
   endtask

   task automatic idle_in();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   // at the falling edge: predict this cycle's controls, compare, stage the model's next state
   task automatic sample();
      bit sf, sd, sa, fd, ba, bw, rd, front;
      logic [8:0] e;
      @(negedge clk);
      sf = 0; sd = 0; sa = 0; fd = 0; ba = 0; bw = 0; rd = 0; front = 0;
      n_halted = m_halted; n_fault = m_fault; n_wait = m_wait;
      n_drain_left = m_drain_left; n_waits_seen = m_waits_seen;
      if (m_halted) begin
         sf = 1; sd = 1; sa = 1; fd = 1; ba = 1; bw = 1;
      end else if (m_drain_left > 0) begin
         sf = 1; fd = 1;
         n_drain_left = m_drain_left - 1;
         if (n_drain_left == 0) n_halted = 1;
      end else if (m_wait) begin
         if (!dc_ready) begin
            sf = 1; sd = 1; sa = 1; bw = 1;
            if (m_waits_seen + 1 >= MAXW) begin
               n_fault = 1; n_halted = 1; n_wait = 0;
            end else begin
               n_waits_seen = m_waits_seen + 1;
            end
         end else begin
            n_wait = 0; front = 1;
         end
      end else if (a_valid && a_is_mem && !dc_ready) begin
         sf = 1; sd = 1; sa = 1; bw = 1;
         n_wait = 1; n_waits_seen = 0;
      end else begin
         front = 1;
      end
      if (front) begin
         if (a_valid && a_mispredict) begin
            rd = 1; fd = 1; ba = 1;
         end else if (a_valid && a_is_load && a_rd_valid && d_valid && d_rs_valid && d_rs == a_rd) begin
            sf = 1; sd = 1; ba = 1;
         end else if (d_valid && d_is_halt) begin
            sf = 1; fd = 1; n_drain_left = 2;
         end
      end
      n_stall = (sf && !m_halted && m_stall < CMAX) ? m_stall + 1 : m_stall;
      n_flush = (rd && m_flush < CMAX) ? m_flush + 1 : m_flush;
      e = {sf, sd, sa, fd, ba, bw, rd, m_halted, m_fault};
      chk("model_outs", 16'(outs()), 16'(e));
      chk("model_stall_cnt", 16'(stall_cnt), 16'(m_stall));
      chk("model_flush_cnt", 16'(flush_cnt), 16'(m_flush));
   endtask

   task automatic advance();
      @(posedge clk);
      m_halted = n_halted; m_fault = n_fault; m_wait = n_wait;
      m_drain_left = n_drain_left; m_waits_seen = n_waits_seen;
      m_stall = n_stall; m_flush = n_flush;
      #1;
   endtask

   // called just after a rising edge; reset takes effect without waiting for a clock
   task automatic do_reset(input string nm);
      n_rst = 1'b0;
      #1;
      chk({nm, "_outs"}, 16'(outs()), 16'h0);
      chk({nm, "_stall_cnt"}, 16'(stall_cnt), 16'h0);
      chk({nm, "_flush_cnt"}, 16'(flush_cnt), 16'h0);
      model_clear();
      @(posedge clk);
      #1;
      n_rst = 1'b1;
   endtask

   typedef struct {
      bit dv, drv; int drs; bit dh;
      bit av, al, am, ardv; int ard; bit amp, dcr;
      logic [8:0] exp;
   } vec_t;

   vec_t tbl[10];

   initial begin
      tbl[0] = '{0,0,0,0, 0,0,0,0,0, 0,1, 9'b000000000};  // idle
      tbl[1] = '{1,1,3,0, 1,1,1,1,3, 0,1, 9'b110010000};  // load r3, D reads r3
      tbl[2] = '{1,1,4,0, 1,1,1,1,3, 0,1, 9'b000000000};  // D reads r4
      tbl[3] = '{1,1,3,0, 1,0,0,1,3, 0,1, 9'b000000000};  // ALU RAW is forwarded
      tbl[4] = '{1,0,3,0, 1,1,1,1,3, 0,1, 9'b000000000};  // D reads no register
      tbl[5] = '{1,1,3,0, 1,1,1,1,3, 1,1, 9'b000110100};  // mispredict beats load-use
      tbl[6] = '{1,0,0,1, 1,0,0,0,0, 1,1, 9'b000110100};  // mispredict kills halt
      tbl[7] = '{1,1,3,0, 0,1,1,1,3, 1,1, 9'b000000000};  // A empty
      tbl[8] = '{1,1,3,0, 1,1,1,0,3, 0,1, 9'b000000000};  // load without rd
      tbl[9] = '{0,1,3,0, 1,1,1,1,3, 0,1, 9'b000000000};  // D empty

      model_clear();
      idle_in();
      #1;
      chk("reset_outs", 16'(outs()), 16'h0);
      chk("reset_stall_cnt", 16'(stall_cnt), 16'h0);
      chk("reset_flush_cnt", 16'(flush_cnt), 16'h0);
      @(posedge clk);
      #1;
      n_rst = 1'b1;

      for (int i = 0; i < 10; i++) begin
         set_in(tbl[i].dv, tbl[i].drv, tbl[i].drs, tbl[i].dh, tbl[i].av, tbl[i].al,
                tbl[i].am, tbl[i].ardv, tbl[i].ard, tbl[i].amp, tbl[i].dcr);
         sample();
         chk($sformatf("vec%0d", i), 16'(outs()), 16'(tbl[i].exp));
         advance();
      end
      idle_in();
      sample();
      chk("vec_still_run", 16'(outs()), 16'h0);
      advance();

      // load-use then the inserted bubble reaches A
      do_reset("rst_lu");
      set_in(1, 1, 3, 0, 1, 1, 1, 1, 3, 0, 1);
      sample();
      chk("lu_stall", 16'({stall_f, stall_d, bubble_a}), 16'h7);
      advance();
      set_in(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1);
      sample();
      chk("lu_release", 16'({stall_f, stall_d, bubble_a}), 16'h0);
      chk("lu_stall_cnt", 16'(stall_cnt), 16'd1);
      advance();

      // mispredict with a concurrent load-use match
      do_reset("rst_mp");
      set_in(1, 1, 3, 0, 1, 1, 1, 1, 3, 1, 1);
      sample();
      chk("mp_ctl", 16'({redirect, flush_d, bubble_a, stall_f}), 16'hE);
      advance();
      idle_in();
      sample();
      chk("mp_flush_cnt", 16'(flush_cnt), 16'd1);
      advance();

      // d_cache wait: low 3 cycles, then ready
      do_reset("rst_mw");
      for (int c = 0; c < 3; c++) begin
         set_in(0, 0, 0, 0, 1, 1, 1, 1, 5, 0, 0);
         sample();
         chk($sformatf("mw_stall%0d", c), 16'({stall_f, stall_d, stall_a, bubble_w}), 16'hF);
         advance();
      end
      set_in(0, 0, 0, 0, 1, 1, 1, 1, 5, 0, 1);
      sample();
      chk("mw_done", 16'({stall_f, stall_d, stall_a, bubble_w}), 16'h0);
      advance();
      set_in(1, 1, 5, 0, 1, 1, 1, 1, 5, 0, 1);
      sample();
      chk("mw_back_run_lu", 16'(outs()), 16'(9'b110010000));
      chk("mw_stall_cnt", 16'(stall_cnt), 16'd3);
      advance();

      // timeout: dc_ready never arrives
      do_reset("rst_to");
      set_in(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
      for (int c = 0; c <= MAXW; c++) begin
         sample();
         chk($sformatf("to_pending%0d", c), 16'({halted, mem_fault}), 16'h0);
         advance();
      end
      for (int c = 0; c < 3; c++) begin
         sample();
         chk($sformatf("to_halted%0d", c), 16'({halted, mem_fault}), 16'h3);
         chk($sformatf("to_stall_cnt%0d", c), 16'(stall_cnt), 16'(MAXW + 1));
         advance();
      end
      do_reset("rst_halted");

      // HALT drains for two cycles, halted on the third
      set_in(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
      for (int c = 0; c < 4; c++) begin
         sample();
         chk($sformatf("halt_t%0d", c), 16'({flush_d, halted}), (c < 3) ? 16'h2 : 16'h3);
         advance();
         idle_in();
      end

      // reset while waiting on d_cache, hazard inputs still asserted
      do_reset("rst_h2");
      set_in(0, 0, 0, 0, 1, 1, 1, 1, 2, 0, 0);
      sample(); advance();
      sample(); advance();
      do_reset("rst_memwait");
      set_in(1, 1, 2, 0, 1, 1, 1, 1, 2, 0, 1);
      sample();
      chk("after_rst_lu", 16'(outs()), 16'(9'b110010000));
      advance();

      // random traffic, with periodic resets so HALTED does not swallow the run
      for (int c = 0; c < 3000; c++) begin
         bit am;
         am = ($urandom % 4) == 0;
         set_in($urandom % 2, $urandom % 2, $urandom % 4, ($urandom % 40) == 0,
                ($urandom % 4) != 0, am & ($urandom % 2), am, $urandom % 2,
                $urandom % 4, ($urandom % 10) == 0, ($urandom % 4) != 0);
         sample();
         advance();
         if (m_halted && ($urandom % 8) == 0) do_reset("rst_rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Central stall/flush sequencer for the four-stage pipelined nand_cpu: fetch, decode, action and writeback. It takes hazard information from the decode and action stages and from the data cache. It drives stall enables to the fetch unit and pipeline registers, bubble/kill controls to the pipeline registers, the fetch redirect, and the processor halt. It also keeps saturating stall/flush event counters for performance debug.

## Interface
- REG_AW, 4: register index width
- MAX_WAIT, 15: max consecutive data-cache wait cycles before fault; 1..255
- CNT_W, 16: width of performance counters

- clk  in  1  clock
- n_rst  in  1  reset; asynchronous, active-low
- d_valid  in  1  decode stage holds a valid instruction
- d_rs_valid  in  1  decode instruction reads a register
- d_rs  in  REG_AW  decode source register
- d_is_halt  in  1  decode instruction is HALT
- a_valid  in  1  action stage holds a valid instruction
- a_is_load  in  1  action instruction is a load
- a_is_mem  in  1  action instruction accesses d_cache (load or store)
- a_rd_valid  in  1  action instruction writes a register
- a_rd  in  REG_AW  action destination register
- a_mispredict  in  1  branch in action resolved against prediction
- dc_ready  in  1  d_cache completes access this cycle
- stall_f  out  1  hold PC / fetch unit
- stall_d  out  1  hold i2d register
- stall_a  out  1  hold d2a register
- flush_d  out  1  load bubble into i2d (kill fetched instruction)
- bubble_a  out  1  load bubble into d2a
- bubble_w  out  1  load bubble into a2w
- redirect  out  1  fetch takes resolved branch target
- halted  out  1  processor halted
- mem_fault  out  1  sticky; d_cache wait exceeded MAX_WAIT
- stall_cnt  out  CNT_W  cycles with stall_f=1 outside HALTED, saturating
- flush_cnt  out  CNT_W  mispredict redirects, saturating

## Operation
- States: RUN, MEM_WAIT, DRAIN, HALTED. Reset → RUN. All outputs 0 at reset; counters 0; mem_fault 0.
- Evaluation in RUN, by priority; first match wins:
  1. mem: a_valid & a_is_mem & !dc_ready → stall_f=stall_d=stall_a=1, bubble_w=1, go MEM_WAIT, wait_cnt=1.
  2. mispredict: a_valid & a_mispredict → redirect=1, flush_d=1, bubble_a=1. A concurrent load-use or halt in D is ignored (wrong path). flush_cnt++.
  3. load-use: a_valid & a_is_load & a_rd_valid & d_valid & d_rs_valid & d_rs==a_rd → stall_f=stall_d=1, bubble_a=1, for exactly one cycle. Non-load RAW is forwarded elsewhere and causes no stall.
  4. halt: d_valid & d_is_halt → stall_f=1, flush_d=1, go DRAIN, drain_cnt=0.
  5. else all controls 0.
- MEM_WAIT:
  - While dc_ready=0, hold stall_f/d/a=1 and bubble_w=1, and increment wait_cnt.
  - If wait_cnt reaches MAX_WAIT with dc_ready still 0: set mem_fault and go HALTED.
  - On dc_ready=1: stalls drop that cycle and the state returns to RUN. The same cycle's rules 2–4 are then evaluated against the current D/A contents.
- DRAIN:
  - stall_f=1 and flush_d=1 every cycle.
  - drain_cnt 0 → 1 → goto HALTED. HALT moves D→A→W over these cycles.
- HALTED: stall_f=stall_d=stall_a=1, flush_d=bubble_a=bubble_w=1, halted=1. Exit only by reset.
- Counters saturate at all-ones; they never wrap.
- Reset asserted mid-operation: immediate return to RUN with all outputs 0, regardless of state.

## Timing
- All control outputs are combinational from the current state plus current inputs, so there is zero-cycle response to hazards. The state, wait_cnt, drain_cnt, mem_fault and counters are registered.
- Load-use costs exactly 1 bubble. A mispredict costs 2 killed slots (F and D).
- halted rises 3 cycles after the cycle in which HALT is detected in D: detect at t → DRAIN at t+1, t+2 → HALTED at t+3.
- MEM_WAIT of N cycles (dc_ready low N cycles after the first) adds N+1 stall cycles total. mem_fault rises on the edge after the MAX_WAIT-th wait cycle.
- stall_cnt increments on the clock edge following any cycle with stall_f=1 and state≠HALTED.

## Test plan
- Load-use: a load to r3 in A with d_rs=3 in D → one cycle of stall_f=stall_d=bubble_a=1, then 0; stall_cnt=1. The same setup with d_rs=4 → no stall.
- Mispredict plus a concurrent load-use match → redirect=flush_d=bubble_a=1, stall_f=0; flush_cnt=1.
- d_cache wait: a_is_mem with dc_ready low for 3 cycles, then high → stall_f/d/a and bubble_w high for 3 cycles, low on the dc_ready cycle; state returns to RUN.
- Timeout with MAX_WAIT=4 and dc_ready held low → mem_fault=1 and halted=1 after the 4th wait cycle; both stay high.
- HALT in D at cycle t → halted=1 at t+3, flush_d high t..t+2. The same HALT with a_mispredict at t → no DRAIN, halted stays 0.
- Reset asserted in MEM_WAIT and in HALTED → all outputs 0 immediately, counters 0, normal RUN after release.
